// File: rtl/patscan_pkg.sv
//============================================================================
// Module      : patscan_pkg
// Description : Shared FSM state encoding and count-width helper for the
//               pattern scan engine.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package patscan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SCAN  = 3'd2,
    ST_WRAP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Width needed to hold any count up to 8*nbytes (the largest possible value).
  function automatic int cnt_width(input int nbytes);
    return $clog2(8 * nbytes + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pattern_scan_engine_if.sv
//============================================================================
// Module      : pattern_scan_engine_if
// Description : Start/done handshake, pattern, byte-memory read port and
//               result counts of the pattern scan engine.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface pattern_scan_engine_if
  import patscan_pkg::*;
#(
  parameter int PAT_W  = 5,
  parameter int NBYTES = 32,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = cnt_width(NBYTES)
);
  logic              req;
  logic              done;
  logic [PAT_W-1:0]  pat;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [CNT_W-1:0]  ctb;
  logic [CNT_W-1:0]  cto;
  logic [CNT_W-1:0]  cts;

  // Requester / memory side
  modport master (output req, pat, rd_data, input done, rd_addr, ctb, cto, cts);
  // Engine side
  modport slave  (input req, pat, rd_data, output done, rd_addr, ctb, cto, cts);
endinterface

`default_nettype wire

// File: rtl/patscan_window_match.sv
//============================================================================
// Module      : patscan_window_match
// Description : Combinational matcher for one byte. The window is the
//               previous PAT_W-1 stream bits followed by the current byte;
//               it reports in-byte matches, an any-in-byte flag, and all
//               matches ending inside the byte (boundary-crossing included).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module patscan_window_match
  import patscan_pkg::*;
#(
  parameter int PAT_W = 5
) (
  input  logic [PAT_W+6:0] win,
  input  logic [PAT_W-1:0] pat,
  output logic [3:0]       inb_cnt,
  output logic             inb_any,
  output logic [3:0]       crs_cnt
);
  logic [7:0] hit;

  // One comparator per window whose lowest bit lands on byte bit i
  for (genvar i = 0; i < 8; i++) begin : g_cmp
    assign hit[i] = (win[i +: PAT_W] == pat);
  end

  // Windows with i <= 8-PAT_W lie wholly inside the byte; the rest borrow history bits
  always_comb begin
    inb_cnt = 4'd0;
    crs_cnt = 4'd0;
    for (int j = 0; j < 8; j++) begin
      if (hit[j]) begin
        crs_cnt = crs_cnt + 4'd1;
        if (j <= 8 - PAT_W) inb_cnt = inb_cnt + 4'd1;
      end
    end
  end

  assign inb_any = (inb_cnt != 4'd0);

endmodule

`default_nettype wire

// File: rtl/pattern_scan_engine.sv
//============================================================================
// Module      : pattern_scan_engine
// Description : Scans NBYTES bytes of memory for a PAT_W-bit pattern and
//               reports in-byte (ctb), per-byte (cto) and bit-stream (cts)
//               match counts. Define PATSCAN_WRAP_EN for circular stream
//               mode (extra WRAP state re-using the top bits of byte 0).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module pattern_scan_engine
  import patscan_pkg::*;
#(
  parameter int PAT_W  = 5,
  parameter int NBYTES = 32,
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  pattern_scan_engine_if.slave bus
);
  localparam int                CNT_W     = cnt_width(NBYTES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NBYTES - 1);

  state_t            state, state_nx;
  logic              accept;
  logic [PAT_W-1:0]  pat_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] idx_q;
  logic              done_q;
  logic [CNT_W-1:0]  ctb_q, cto_q, cts_q;
  logic [7:0]        byte_in;
  logic [PAT_W+6:0]  win;
  logic [3:0]        inb_cnt, crs_cnt;
  logic              inb_any;

`ifdef PATSCAN_WRAP_EN
  logic [7:0] byte0_q;

  // The whole byte 0 is kept so the matcher sees a real byte in WRAP; only
  // its boundary-crossing windows (top PAT_W-1 bits) are added there.
  always_ff @(posedge clk) begin
    if (reset)                                byte0_q <= 8'd0;
    else if (state == ST_SCAN && idx_q == '0) byte0_q <= bus.rd_data;
  end

  assign byte_in = (state == ST_WRAP) ? byte0_q : bus.rd_data;
`else
  assign byte_in = bus.rd_data;
`endif

  if (PAT_W > 1) begin : g_hist
    logic [PAT_W-2:0] hist_q;

    // Last PAT_W-1 stream bits, cleared on each new scan so the first byte sees no history
    always_ff @(posedge clk) begin
      if (reset || accept)      hist_q <= '0;
      else if (state == ST_SCAN) hist_q <= bus.rd_data[PAT_W-2:0];
    end

    assign win = {hist_q, byte_in};
  end else begin : g_no_hist
    assign win = byte_in;
  end

  patscan_window_match #(.PAT_W(PAT_W)) u_match (
    .win     (win),
    .pat     (pat_q),
    .inb_cnt (inb_cnt),
    .inb_any (inb_any),
    .crs_cnt (crs_cnt)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; a request is only taken in IDLE or DONE
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req) begin
          accept   = 1'b1;
          state_nx = ST_FETCH;
        end
      end
      ST_FETCH: state_nx = ST_SCAN;
      ST_SCAN: begin
        if (idx_q == LAST_ADDR) begin
`ifdef PATSCAN_WRAP_EN
          state_nx = ST_WRAP;
`else
          state_nx = ST_DONE;
`endif
        end
      end
      ST_WRAP: state_nx = ST_DONE;
      ST_DONE: begin
        if (bus.req) begin
          accept   = 1'b1;
          state_nx = ST_FETCH;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Address issue, byte consumption and count accumulation
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q  <= '0;
      addr_q <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
      ctb_q  <= '0;
      cto_q  <= '0;
      cts_q  <= '0;
    end else if (accept) begin
      pat_q  <= bus.pat;
      addr_q <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
      ctb_q  <= '0;
      cto_q  <= '0;
      cts_q  <= '0;
    end else begin
      case (state)
        ST_FETCH: addr_q <= addr_q + ADDR_W'(1);
        ST_SCAN: begin
          if (addr_q != LAST_ADDR) addr_q <= addr_q + ADDR_W'(1);
          idx_q <= idx_q + ADDR_W'(1);
          ctb_q <= ctb_q + CNT_W'(inb_cnt);
          cto_q <= cto_q + CNT_W'(inb_any);
          // Byte 0 has no real history: crossing windows would start before bit 0
          cts_q <= cts_q + ((idx_q == '0) ? CNT_W'(inb_cnt) : CNT_W'(crs_cnt));
        end
`ifdef PATSCAN_WRAP_EN
        ST_WRAP: cts_q <= cts_q + CNT_W'(crs_cnt - inb_cnt);
`endif
        ST_DONE: done_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.done    = done_q;
  assign bus.rd_addr = addr_q;
  assign bus.ctb     = ctb_q;
  assign bus.cto     = cto_q;
  assign bus.cts     = cts_q;

endmodule

`default_nettype wire

// File: tb/tb_pattern_scan_engine.sv
//============================================================================
// Module      : tb_pattern_scan_engine
// Description : Self-checking bench for pattern_scan_engine (default build
//               and PATSCAN_WRAP_EN build), default and 8-bit/4-byte configs.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_pattern_scan_engine;
  import patscan_pkg::*;

  localparam int NB  = 32;
  localparam int NB8 = 4;
  localparam int CW  = cnt_width(NB);
  localparam int CW8 = cnt_width(NB8);
`ifdef PATSCAN_WRAP_EN
  localparam int XTRA = 1;
`else
  localparam int XTRA = 0;
`endif

  typedef struct {
    int ctb;
    int cto;
    int cts;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  logic [7:0] mem  [32];
  logic [7:0] mem8 [4];

  always #5 clk = ~clk;

  pattern_scan_engine_if #(.PAT_W(5), .NBYTES(NB),  .ADDR_W(8)) bus  ();
  pattern_scan_engine_if #(.PAT_W(8), .NBYTES(NB8), .ADDR_W(2)) bus8 ();

  pattern_scan_engine #(.PAT_W(5), .NBYTES(NB), .ADDR_W(8)) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  pattern_scan_engine #(.PAT_W(8), .NBYTES(NB8), .ADDR_W(2)) u_dut8 (
    .clk(clk), .reset(reset), .bus(bus8)
  );

  // Byte memories with one cycle read latency
  always @(posedge clk) begin
    bus.rd_data  <= mem[bus.rd_addr[4:0]];
    bus8.rd_data <= mem8[bus8.rd_addr];
  end

  // Reference: explicit bit-stream walk over the memory contents
  function automatic exp_t model(input int pw, input int nb, input logic [7:0] m [32], input int p);
    exp_t e;
    logic s [264];
    int   tot, nw, v, hits;
    e.ctb = 0; e.cto = 0; e.cts = 0;
    for (int i = 0; i < nb; i++) begin
      hits = 0;
      for (int k = 0; k <= 8 - pw; k++) begin
        v = (int'(m[i]) >> k) & ((1 << pw) - 1);
        if (v == p) hits++;
      end
      e.ctb += hits;
      if (hits > 0) e.cto++;
      for (int j = 0; j < 8; j++) s[8*i+j] = m[i][7-j];
    end
    tot = 8 * nb;
`ifdef PATSCAN_WRAP_EN
    for (int j = 0; j < pw - 1; j++) s[tot+j] = s[j];
    nw = tot;
`else
    nw = tot - pw + 1;
`endif
    for (int st = 0; st < nw; st++) begin
      v = 0;
      for (int b = 0; b < pw; b++) v = (v << 1) | int'(s[st+b]);
      if (v == p) e.cts++;
    end
    return e;
  endfunction

  task automatic start(input logic [7:0] p, input bit use8);
    @(negedge clk);
    if (use8) begin bus8.pat = p; bus8.req = 1'b1; end
    else      begin bus.pat = p[4:0]; bus.req = 1'b1; end
    @(posedge clk); #1;
    bus.req  = 1'b0;
    bus8.req = 1'b0;
  endtask

  // Cycles from accept edge until done seen; -1 on timeout. poke_at > 0 pulses a stray req.
  task automatic wait_done(input bit use8, input int poke_at, output int lat);
    int c;
    lat = -1;
    c   = 0;
    while (lat < 0 && c < 300) begin
      @(posedge clk); #1;
      c++;
      if (poke_at > 0 && c == poke_at + 1) bus.req = 1'b0;
      if ((use8 ? bus8.done : bus.done) === 1'b1) lat = c;
      else if (poke_at > 0 && c == poke_at) begin bus.req = 1'b1; bus.pat = 5'h00; end
    end
    bus.req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.ctb !== CW'(0))  begin errors++; $display("FAIL reset_ctb: got %0d expected 0", bus.ctb); end
    checks++; if (bus.cto !== CW'(0))  begin errors++; $display("FAIL reset_cto: got %0d expected 0", bus.cto); end
    checks++; if (bus.cts !== CW'(0))  begin errors++; $display("FAIL reset_cts: got %0d expected 0", bus.cts); end
    checks++; if (bus.rd_addr !== 8'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", bus.rd_addr); end
    checks++; if (bus8.done !== 1'b0)  begin errors++; $display("FAIL reset_done8: got %b expected 0", bus8.done); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_scan_default(input string name, input logic [7:0] p);
    exp_t e;
    int   lat;
    start(p, 1'b0);
    wait_done(1'b0, 0, lat);
    e = sb.pop_front();
    checks++; if (lat != NB + 2 + XTRA)  begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, NB + 2 + XTRA); end
    checks++; if (bus.ctb !== CW'(e.ctb)) begin errors++; $display("FAIL %s_ctb: got %0d expected %0d", name, bus.ctb, e.ctb); end
    checks++; if (bus.cto !== CW'(e.cto)) begin errors++; $display("FAIL %s_cto: got %0d expected %0d", name, bus.cto, e.cto); end
    checks++; if (bus.cts !== CW'(e.cts)) begin errors++; $display("FAIL %s_cts: got %0d expected %0d", name, bus.cts, e.cts); end
  endtask

  task automatic test_alternating();
    foreach (mem[i]) mem[i] = 8'h55;
    sb.push_back(exp_t'{64, 32, (XTRA != 0) ? 128 : 126});
    check_scan_default("alt55", 8'h15);
  endtask

  task automatic test_zeros();
    foreach (mem[i]) mem[i] = 8'h00;
    sb.push_back(exp_t'{128, 32, (XTRA != 0) ? 256 : 252});
    check_scan_default("zeros", 8'h00);
  endtask

  task automatic test_boundary();
    foreach (mem[i]) mem[i] = 8'h00;
    mem[0] = 8'h07;
    sb.push_back(exp_t'{0, 0, 1});
    check_scan_default("boundary", 8'h1C);
  endtask

  task automatic test_random();
    logic [7:0] p;
    for (int it = 0; it < 3; it++) begin
      foreach (mem[i]) mem[i] = 8'($urandom);
      p = 8'($urandom_range(0, 31));
      sb.push_back(model(5, NB, mem, int'(p)));
      check_scan_default("random", p);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    foreach (mem[i]) mem[i] = 8'($urandom);
    sb.push_back(model(5, NB, mem, 9));
    check_scan_default("b2b_first", 8'h09);
    sb.push_back(model(5, NB, mem, 22));
    start(8'h16, 1'b0);
    checks++; if (bus.done !== 1'b0)    begin errors++; $display("FAIL b2b_done_clear: got %b expected 0", bus.done); end
    checks++; if (bus.rd_addr !== 8'd0) begin errors++; $display("FAIL b2b_addr_zero: got %0d expected 0", bus.rd_addr); end
    checks++; if (bus.ctb !== CW'(0))   begin errors++; $display("FAIL b2b_ctb_clear: got %0d expected 0", bus.ctb); end
    wait_done(1'b0, 0, lat);
    e = sb.pop_front();
    checks++; if (lat != NB + 2 + XTRA)  begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", lat, NB + 2 + XTRA); end
    checks++; if (bus.ctb !== CW'(e.ctb)) begin errors++; $display("FAIL b2b_ctb: got %0d expected %0d", bus.ctb, e.ctb); end
    checks++; if (bus.cto !== CW'(e.cto)) begin errors++; $display("FAIL b2b_cto: got %0d expected %0d", bus.cto, e.cto); end
    checks++; if (bus.cts !== CW'(e.cts)) begin errors++; $display("FAIL b2b_cts: got %0d expected %0d", bus.cts, e.cts); end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int   lat;
    foreach (mem[i]) mem[i] = 8'h55;
    start(8'h15, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset   = 1'b1;
    bus.req = 1'b1;
    bus.pat = 5'h00;
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0)    begin errors++; $display("FAIL abort_done: got %b expected 0", bus.done); end
    checks++; if (bus.ctb !== CW'(0))   begin errors++; $display("FAIL abort_ctb: got %0d expected 0", bus.ctb); end
    checks++; if (bus.cto !== CW'(0))   begin errors++; $display("FAIL abort_cto: got %0d expected 0", bus.cto); end
    checks++; if (bus.cts !== CW'(0))   begin errors++; $display("FAIL abort_cts: got %0d expected 0", bus.cts); end
    checks++; if (bus.rd_addr !== 8'd0) begin errors++; $display("FAIL abort_addr: got %0d expected 0", bus.rd_addr); end
    @(negedge clk);
    bus.req = 1'b0;
    reset   = 1'b0;
    repeat (NB + 4) @(posedge clk);
    #1;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_req_ignored: done got %b expected 0", bus.done); end
    sb.push_back(model(5, NB, mem, 21));
    start(8'h15, 1'b0);
    wait_done(1'b0, 5, lat);
    e = sb.pop_front();
    checks++; if (lat != NB + 2 + XTRA)  begin errors++; $display("FAIL rescan_latency: got %0d expected %0d", lat, NB + 2 + XTRA); end
    checks++; if (bus.ctb !== CW'(e.ctb)) begin errors++; $display("FAIL rescan_ctb: got %0d expected %0d", bus.ctb, e.ctb); end
    checks++; if (bus.cto !== CW'(e.cto)) begin errors++; $display("FAIL rescan_cto: got %0d expected %0d", bus.cto, e.cto); end
    checks++; if (bus.cts !== CW'(e.cts)) begin errors++; $display("FAIL rescan_cts: got %0d expected %0d", bus.cts, e.cts); end
  endtask

  task automatic test_w8();
    exp_t e;
    int   lat;
    mem8[0] = 8'hA5; mem8[1] = 8'h00; mem8[2] = 8'hA5; mem8[3] = 8'h5A;
    sb.push_back(exp_t'{2, 2, 2});
    start(8'hA5, 1'b1);
    wait_done(1'b1, 0, lat);
    e = sb.pop_front();
    checks++; if (lat != 6 + XTRA)          begin errors++; $display("FAIL w8_latency: got %0d expected %0d", lat, 6 + XTRA); end
    checks++; if (bus8.ctb !== CW8'(e.ctb)) begin errors++; $display("FAIL w8_ctb: got %0d expected %0d", bus8.ctb, e.ctb); end
    checks++; if (bus8.cto !== CW8'(e.cto)) begin errors++; $display("FAIL w8_cto: got %0d expected %0d", bus8.cto, e.cto); end
    checks++; if (bus8.cts !== CW8'(e.cts)) begin errors++; $display("FAIL w8_cts: got %0d expected %0d", bus8.cts, e.cts); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus8.done !== 1'b1)       begin errors++; $display("FAIL w8_done_hold: got %b expected 1", bus8.done); end
    checks++; if (bus8.cts !== CW8'(e.cts)) begin errors++; $display("FAIL w8_cts_hold: got %0d expected %0d", bus8.cts, e.cts); end
  endtask

  initial begin
    bus.req  = 1'b0;
    bus.pat  = '0;
    bus8.req = 1'b0;
    bus8.pat = '0;
    foreach (mem[i])  mem[i]  = 8'h00;
    foreach (mem8[i]) mem8[i] = 8'h00;
    test_reset();
    test_alternating();
    test_zeros();
    test_boundary();
    test_random();
    test_back_to_back();
    test_reset_abort();
    test_w8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pattern_scan_engine.md
PATTERN_SCAN_ENGINE -- requirements
Module: pattern_scan_engine

Interface
REQ-001 SHALL have parameter PAT_W, default 5, pattern width in bits, legal 1..8.
REQ-002 SHALL have parameter NBYTES, default 32, length of the searched string in bytes, legal 2..256.
REQ-003 SHALL have parameter ADDR_W, default 8, memory address width, with 2**ADDR_W >= NBYTES.
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge; reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: req  in  1  start pulse; done  out  1  scan complete.
REQ-006 SHALL have ports: pat  in  PAT_W  pattern to search for, sampled when req is accepted.
REQ-007 SHALL have ports: rd_addr  out  ADDR_W  byte address; rd_data  in  8  byte data, valid one cycle after rd_addr.
REQ-008 SHALL have ports: ctb, cto, cts  out  CNT_W each; CNT_W = $clog2(8*NBYTES+1); meanings per REQ-013..015.

Function
REQ-009 SHALL implement FSM IDLE -> FETCH -> SCAN -> (WRAP if enabled) -> DONE -> IDLE.
REQ-010 SHALL accept req only in IDLE or DONE; req in FETCH/SCAN/WRAP SHALL be ignored.
REQ-011 On accept, SHALL latch pat, clear all counts, deassert done, and drive rd_addr=0.
REQ-012 SHALL issue addresses 0..NBYTES-1 on consecutive cycles and consume one byte per cycle; done SHALL rise exactly NBYTES+2 cycles after accept (NBYTES+3 with wrap).
REQ-013 ctb SHALL count, over all bytes, the in-byte windows byte[k+PAT_W-1:k], k=0..8-PAT_W, that equal pat.
REQ-014 cto SHALL count the bytes containing at least one matching in-byte window.
REQ-015 cts SHALL count matching windows in the bit stream formed by byte 0 first, each byte MSB first; a window is PAT_W consecutive stream bits read MSB-first; 8*NBYTES-PAT_W+1 windows are counted, including those crossing byte boundaries.
REQ-016 SHALL hold the previous PAT_W-1 stream bits in a history register; windows that would start before stream bit 0 SHALL NOT be counted.
REQ-017 done SHALL remain high, with counts stable, until the next accepted req or reset.
REQ-018 Counts SHALL NOT saturate or wrap; CNT_W covers the maximum of each count.
REQ-019 If req coincides with reset, reset SHALL win.

Reset
REQ-020 Reset SHALL force IDLE, done=0, ctb=cto=cts=0, rd_addr=0, history=0, latched pattern=0.
REQ-021 Reset mid-scan SHALL abort the scan; no partial counts SHALL survive.

Configuration
REQ-022 Macro PATSCAN_WRAP_EN SHALL select circular mode.
- Defined: WRAP state appends the top PAT_W-1 bits of byte 0 (held from the first fetch, not re-read) after byte NBYTES-1, so cts counts 8*NBYTES windows; ctb and cto are unchanged.
- Undefined: no WRAP state; linear behaviour as in REQ-015.

Structure
REQ-023 Package patscan_pkg SHALL hold the FSM state enum and a function computing CNT_W from NBYTES.
REQ-024 A combinational sub-module patscan_window_match SHALL take a (PAT_W-1+8)-bit window and the pattern, and return the in-byte match count, the any-in-byte flag and the crossing-inclusive match count for that byte.

Verification
REQ-025 Defaults, pat=10101, all bytes 0x55 -> ctb=64, cto=32, cts=126 (wrap: 128).
REQ-026 Defaults, pat=00000, all bytes 0x00 -> ctb=128, cto=32, cts=252 (wrap: 256).
REQ-027 Defaults, pat=11100, byte0=0x07, all other bytes 0x00 -> ctb=0, cto=0, cts=1 (boundary-only match).
REQ-028 PAT_W=8, NBYTES=4, pat=0xA5, bytes {0xA5,0x00,0xA5,0x5A} -> ctb=2, cto=2, cts=2; done asserted 6 cycles after accept.
REQ-029 Reset asserted 10 cycles after accept, then a new req -> done=0 and counts 0 during reset; a fresh full scan then gives the correct counts; a req pulsed during the scan is ignored.
